// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes,
// FSM state encoding and default widths.
package mips_muldiv_pkg;

    localparam int XLEN_DEF = 32;
    localparam int ITER_DEF = 32;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/adder_32bits.sv
// 32-bit ripple-style adder with carry in/out; the shared add/subtract step
// of the multiply/divide sequencer.
module adder_32bits (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {32'b0, ci};

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Optional multiply early-out when built with `define MULDIV_EARLY_OUT_EN.
module muldiv_sequencer
    import mips_muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int ITER = ITER_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      MDCode,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            rd_hilo,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic            div_zero,
    output logic [XLEN-1:0] HI,
    output logic [XLEN-1:0] LO
);

    localparam int CNT_W = $clog2(ITER);
    localparam int SH_W  = CNT_W + 1;

    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] x);
        return ~x + XLEN'(1);
    endfunction

    function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] x);
        return ~x + (2*XLEN)'(1);
    endfunction

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? neg_w(x) : x;
    endfunction

    md_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] p_hi_q, p_lo_q, opnd_q;
    logic            op_div_q, sign_a_q, sign_b_q, dz_q;

    logic code_long, code_div, code_signed, b_zero, accept_long, last_iter, early_out;
    logic [XLEN-1:0] sh_hi, add_a, add_b, add_s;
    logic            add_co, no_borrow, mul_c;
    logic [XLEN-1:0] mul_sum, run_hi, run_lo, wb_hi, wb_lo;
    logic [2*XLEN-1:0] prod;

    assign code_long   = (MDCode == MD_MULT) || (MDCode == MD_MULTU) ||
                         (MDCode == MD_DIV)  || (MDCode == MD_DIVU);
    assign code_div    = (MDCode == MD_DIV)  || (MDCode == MD_DIVU);
    assign code_signed = (MDCode == MD_MULT) || (MDCode == MD_DIV);
    assign b_zero      = (B == '0);
    assign accept_long = (state_q == S_IDLE) && start && code_long;
    assign last_iter   = (cnt_q == CNT_W'(ITER - 1));

    assign busy  = (state_q != S_IDLE);
    assign stall = busy & (start | rd_hilo);

    // Shared step: multiply adds the multiplicand to P_hi; divide subtracts
    // the divisor from the left-shifted P_hi via inverted b and carry-in.
    assign sh_hi = {p_hi_q[XLEN-2:0], p_lo_q[XLEN-1]};
    assign add_a = op_div_q ? sh_hi : p_hi_q;
    assign add_b = op_div_q ? ~opnd_q : opnd_q;

    adder_32bits u_step (
        .a  (add_a),
        .b  (add_b),
        .ci (op_div_q),
        .s  (add_s),
        .co (add_co)
    );

    // The bit shifted out of P_hi makes the partial remainder 33 bits wide.
    assign no_borrow = add_co | p_hi_q[XLEN-1];
    assign mul_sum   = p_lo_q[0] ? add_s : p_hi_q;
    assign mul_c     = p_lo_q[0] & add_co;

`ifdef MULDIV_EARLY_OUT_EN
    logic [XLEN-1:0]   rem_mask;
    logic [SH_W-1:0]   rem_cnt;
    logic [2*XLEN-1:0] acc_sh;

    assign rem_mask  = {XLEN{1'b1}} >> cnt_q;
    assign rem_cnt   = SH_W'(ITER) - {1'b0, cnt_q};
    assign acc_sh    = {p_hi_q, p_lo_q} >> rem_cnt;
    assign early_out = !op_div_q && ((p_lo_q & rem_mask) == '0);
`else
    assign early_out = 1'b0;
`endif

    always_comb begin
        if (op_div_q) begin
            run_hi = no_borrow ? add_s : sh_hi;
            run_lo = {p_lo_q[XLEN-2:0], no_borrow};
        end else begin
            run_hi = {mul_c, mul_sum[XLEN-1:1]};
            run_lo = {mul_sum[0], p_lo_q[XLEN-1:1]};
        end
`ifdef MULDIV_EARLY_OUT_EN
        if (early_out) begin
            {run_hi, run_lo} = acc_sh;
        end
`endif
    end

    always_comb begin
        prod  = {p_hi_q, p_lo_q};
        wb_hi = p_hi_q;
        wb_lo = p_lo_q;
        if (dz_q) begin
            wb_hi = p_lo_q;
            wb_lo = '1;
        end else if (op_div_q) begin
            wb_lo = (sign_a_q ^ sign_b_q) ? neg_w(p_lo_q) : p_lo_q;
            wb_hi = sign_a_q ? neg_w(p_hi_q) : p_hi_q;
        end else begin
            if (sign_a_q ^ sign_b_q) prod = neg_dw(prod);
            wb_hi = prod[2*XLEN-1:XLEN];
            wb_lo = prod[XLEN-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept_long) state_d = (code_div && b_zero) ? S_DONE : S_RUN;
            S_RUN:  if (last_iter || early_out) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control and architectural HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dz_q     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            HI       <= '0;
            LO       <= '0;
        end else begin
            state_q <= state_d;
            done    <= (state_q == S_DONE);
            if (accept_long) begin
                cnt_q    <= '0;
                op_div_q <= code_div;
                sign_a_q <= code_signed & A[XLEN-1];
                sign_b_q <= code_signed & B[XLEN-1];
                dz_q     <= code_div & b_zero;
                div_zero <= code_div & b_zero;
            end else if (state_q == S_IDLE && start && MDCode == MD_MTHI) begin
                HI       <= A;
                div_zero <= 1'b0;
            end else if (state_q == S_IDLE && start && MDCode == MD_MTLO) begin
                LO       <= A;
                div_zero <= 1'b0;
            end else if (state_q == S_RUN) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (state_q == S_DONE) begin
                HI <= wb_hi;
                LO <= wb_lo;
            end
        end
    end

    // Accumulator and operand datapath
    always_ff @(posedge clk) begin
        if (accept_long) begin
            p_hi_q <= '0;
            if (code_div && b_zero) begin
                p_lo_q <= A;
                opnd_q <= B;
            end else if (code_div) begin
                p_lo_q <= mag(A, code_signed);
                opnd_q <= mag(B, code_signed);
            end else begin
                p_lo_q <= mag(B, code_signed);
                opnd_q <= mag(A, code_signed);
            end
        end else if (state_q == S_RUN) begin
            p_hi_q <= run_hi;
            p_lo_q <= run_lo;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and randomized check of muldiv_sequencer against a plain-arithmetic
// reference model of MULT/MULTU/DIV/DIVU/MTHI/MTLO.
module tb_muldiv_sequencer;
    import mips_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  MDCode;
    logic [31:0] A, B;
    logic        rd_hilo;
    logic        busy, stall, done, div_zero;
    logic [31:0] HI, LO;

    int total = 0;
    int bad   = 0;

    muldiv_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .MDCode   (MDCode),
        .A        (A),
        .B        (B),
        .rd_hilo  (rd_hilo),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .div_zero (div_zero),
        .HI       (HI),
        .LO       (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit integer arithmetic; SV division truncates toward zero
    // and the remainder follows the dividend, which is the MIPS rule.
    task automatic model(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (code)
            MD_MULT:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            MD_MULTU: begin p = ua * ub; hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1;
                end else begin
                    if (code == MD_DIV) begin q = sa / sb; r = sa % sb; end
                    else begin q = longint'(ua / ub); r = longint'(ua % ub); end
                    p = q; lo = p[31:0];
                    p = r; hi = p[31:0];
                end
            end
        endcase
    endtask

    task automatic run_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dz,
                          input int exp_lat, input logic hold_rd, input logic restart);
        int   cyc;
        int   guard;
        logic stall_ok;
        @(negedge clk);
        start = 1'b1; MDCode = code; A = a; B = b;
        @(negedge clk);
        start = 1'b0; rd_hilo = hold_rd;
        cyc = 0; guard = 0; stall_ok = 1'b1;
        while (done !== 1'b1 && guard < 100) begin
            guard++;
            if (busy === 1'b1) cyc++;
            if (hold_rd && stall !== 1'b1) stall_ok = 1'b0;
            if (restart && cyc == 5) begin
                start = 1'b1; MDCode = MD_DIVU; A = 32'd99; B = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("latency", 32'(cyc), 32'(exp_lat));
        chk("done_hi", {31'b0, done}, 32'd1);
        chk("busy_after", {31'b0, busy}, 32'd0);
        chk("HI", HI, exp_hi);
        chk("LO", LO, exp_lo);
        chk("div_zero", {31'b0, div_zero}, {31'b0, exp_dz});
        if (hold_rd) begin
            chk("stall_while_busy", {31'b0, stall_ok}, 32'd1);
            chk("stall_idle", {31'b0, stall}, 32'd0);
        end
        rd_hilo = 1'b0;
        @(negedge clk);
        chk("done_pulse", {31'b0, done}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  code;
        logic [31:0] a, b, eh, el;
        logic        edz;
        rst_n = 1'b0; start = 1'b0; MDCode = 3'b000; A = '0; B = '0; rd_hilo = 1'b0;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_div_zero", {31'b0, div_zero}, 32'd0);
        chk("rst_HI", HI, 32'd0);
        chk("rst_LO", LO, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(MD_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 1'b0, 1'b0);
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 1'b0, 1'b0);
        run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 1'b0, 1'b0);
        run_op(MD_DIVU,  32'd7,         32'd2,        32'd1,         32'd3,         1'b0, 33, 1'b0, 1'b0);
        run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0, 33, 1'b0, 1'b0);
        run_op(MD_DIVU,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b1, 1,  1'b0, 1'b0);

        // MTHI while idle: written next edge, never busy, clears div_zero
        @(negedge clk);
        start = 1'b1; MDCode = MD_MTHI; A = 32'h0000_1234; B = '0;
        @(negedge clk);
        start = 1'b0;
        chk("mthi_HI", HI, 32'h0000_1234);
        chk("mthi_LO_kept", LO, 32'hFFFF_FFFF);
        chk("mthi_busy", {31'b0, busy}, 32'd0);
        chk("mthi_done", {31'b0, done}, 32'd0);
        chk("mthi_clears_dz", {31'b0, div_zero}, 32'd0);

        @(negedge clk);
        start = 1'b1; MDCode = MD_MTLO; A = 32'hCAFE_0042;
        @(negedge clk);
        start = 1'b0; MDCode = 3'b110; A = 32'h5555_5555;
        chk("mtlo_LO", LO, 32'hCAFE_0042);
        chk("mtlo_HI_kept", HI, 32'h0000_1234);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("reserved_busy", {31'b0, busy}, 32'd0);
        chk("reserved_HI", HI, 32'h0000_1234);
        chk("reserved_LO", LO, 32'hCAFE_0042);
        rd_hilo = 1'b1;
        #1 chk("rd_idle_stall", {31'b0, stall}, 32'd0);
        rd_hilo = 1'b0;

        // Stall held by rd_hilo, plus an ignored second start mid-operation
        run_op(MD_MULT, 32'h0000_1234, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_DB98, 1'b0, 33, 1'b1, 1'b1);

        for (int i = 0; i < 24; i++) begin
            code = 3'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: a = 32'h8000_0000;
                3: b = 32'hFFFF_FFFF;
                default: ;
            endcase
            model(code, a, b, eh, el, edz);
            run_op(code, a, b, eh, el, edz, edz ? 1 : 33, 1'($urandom_range(0, 1)), 1'b0);
        end

        // Asynchronous reset during RUN abandons the op immediately
        @(negedge clk);
        start = 1'b1; MDCode = MD_MULT; A = 32'h1357_9BDF; B = 32'h0246_8ACE;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_HI", HI, 32'd0);
        chk("arst_LO", LO, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        chk("arst_div_zero", {31'b0, div_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {31'b0, busy}, 32'd0);

        a = $urandom; b = $urandom;
        model(MD_MULTU, a, b, eh, el, edz);
        run_op(MD_MULTU, a, b, eh, el, edz, 33, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
